// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring) engine.
// It delivers the 64-bit HI/LO result pair to the multicycle control unit.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mult_start,
    input  logic             div_start,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MULT   = 2'd1,
        S_DIV    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + W_ONE;
    endfunction

    // Magnitude of a two's complement value; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? negate(v) : v;
    endfunction

    state_t           state_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] mcand_r;     // multiplicand, or divisor magnitude
    logic [WIDTH-1:0] acc_hi_r;    // Booth P_hi, or partial remainder
    logic [WIDTH-1:0] acc_lo_r;    // Booth P_lo, or dividend/quotient shifter
    logic             q_m1_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic [WIDTH-1:0] res_hi_r;
    logic [WIDTH-1:0] res_lo_r;
    logic             busy_r;
    logic             done_r;
    logic             div_zero_r;

    logic [WIDTH:0]   hi_ext_s;
    logic [WIDTH:0]   mc_ext_s;
    logic [WIDTH:0]   booth_sum_s;
    logic [WIDTH-1:0] booth_hi_s;
    logic [WIDTH-1:0] booth_lo_s;
    logic [WIDTH:0]   div_trial_s;
    logic [WIDTH-1:0] div_rem_s;
    logic [WIDTH-1:0] div_quo_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;

    assign hi_ext_s = {acc_hi_r[WIDTH-1], acc_hi_r};
    assign mc_ext_s = {mcand_r[WIDTH-1], mcand_r};

    // Booth add/subtract step on the sign-extended upper half.
    always_comb begin
        booth_sum_s = hi_ext_s;
        case ({acc_lo_r[0], q_m1_r})
            2'b01:   booth_sum_s = hi_ext_s + mc_ext_s;
            2'b10:   booth_sum_s = hi_ext_s - mc_ext_s;
            default: booth_sum_s = hi_ext_s;
        endcase
    end

    assign booth_hi_s  = booth_sum_s[WIDTH:1];
    assign booth_lo_s  = {booth_sum_s[0], acc_lo_r[WIDTH-1:1]};
    assign div_trial_s = {acc_hi_r, acc_lo_r[WIDTH-1]} - {1'b0, mcand_r};

    // Restoring divide step: keep the trial difference only when it did not borrow.
    always_comb begin
        div_rem_s = W_ZERO;
        div_quo_s = W_ZERO;
        if (!div_trial_s[WIDTH]) begin
            div_rem_s = div_trial_s[WIDTH-1:0];
            div_quo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_s = {acc_hi_r[WIDTH-2:0], acc_lo_r[WIDTH-1]};
            div_quo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
        end
    end

    assign quo_fix_s = neg_q_r ? negate(div_quo_s) : div_quo_s;
    assign rem_fix_s = neg_r_r ? negate(div_rem_s) : div_rem_s;

    // Control FSM with datapath registers and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= S_IDLE;
            count_r    <= CNT_ZERO;
            mcand_r    <= W_ZERO;
            acc_hi_r   <= W_ZERO;
            acc_lo_r   <= W_ZERO;
            q_m1_r     <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            res_hi_r   <= W_ZERO;
            res_lo_r   <= W_ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (mult_start) begin
                        mcand_r  <= op_a;
                        acc_hi_r <= W_ZERO;
                        acc_lo_r <= op_b;
                        q_m1_r   <= 1'b0;
                        count_r  <= CNT_ZERO;
                        busy_r   <= 1'b1;
                        state_r  <= S_MULT;
                    end else if (div_start && (op_b != W_ZERO)) begin
                        mcand_r  <= magnitude(op_b);
                        acc_hi_r <= W_ZERO;
                        acc_lo_r <= magnitude(op_a);
                        neg_q_r  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        neg_r_r  <= op_a[WIDTH-1];
                        count_r  <= CNT_ZERO;
                        busy_r   <= 1'b1;
                        state_r  <= S_DIV;
                    end else if (div_start) begin
                        // Divide by zero: results keep their previous values.
                        done_r     <= 1'b1;
                        div_zero_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= S_FINISH;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_MULT: begin
                    acc_hi_r <= booth_hi_s;
                    acc_lo_r <= booth_lo_s;
                    q_m1_r   <= acc_lo_r[0];
                    count_r  <= count_r + CNT_ONE;
                    if (count_r == CNT_LAST) begin
                        res_hi_r <= booth_hi_s;
                        res_lo_r <= booth_lo_s;
                        done_r   <= 1'b1;
                        state_r  <= S_FINISH;
                    end
                end
                S_DIV: begin
                    acc_hi_r <= div_rem_s;
                    acc_lo_r <= div_quo_s;
                    count_r  <= count_r + CNT_ONE;
                    if (count_r == CNT_LAST) begin
                        res_hi_r <= rem_fix_s;
                        res_lo_r <= quo_fix_s;
                        done_r   <= 1'b1;
                        state_r  <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign result_hi = res_hi_r;
    assign result_lo = res_lo_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed vectors.
module tb_mult_div_unit;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             mult_start;
    logic             div_start;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int cyc = 0;
    int ndone;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .op_a       (op_a),
        .op_b       (op_b),
        .mult_start (mult_start),
        .div_start  (div_start),
        .result_hi  (result_hi),
        .result_lo  (result_lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Start strobe is sampled at edge 0; returns in cycle 1.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic m, input logic d);
        op_a       = a;
        op_b       = b;
        mult_start = m;
        div_start  = d;
        cyc        = 0;
        step();
        mult_start = 1'b0;
        div_start  = 1'b0;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && cyc < 100) step();
    endtask

    task automatic count_dones(input int n, output int k);
        k = 0;
        repeat (n) begin
            step();
            if (done === 1'b1) k++;
        end
    endtask

    task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic m, input logic d,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                             input int exp_lat, input logic exp_dz);
        launch(a, b, m, d);
        check_eq({tag, "_busy1"}, 64'(busy), 64'd1);
        wait_done();
        check_eq({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        check_eq({tag, "_hi"}, 64'(result_hi), 64'(exp_hi));
        check_eq({tag, "_lo"}, 64'(result_lo), 64'(exp_lo));
        check_eq({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
        check_eq({tag, "_busy_done"}, 64'(busy), 64'd1);
        step();
        check_eq({tag, "_done_after"}, 64'(done), 64'd0);
        check_eq({tag, "_dz_after"}, 64'(div_zero), 64'd0);
        check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        op_a       = 32'd0;
        op_b       = 32'd0;
        mult_start = 1'b0;
        div_start  = 1'b0;
        step();
        step();
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_dz", 64'(div_zero), 64'd0);
        check_eq("rst_hi", 64'(result_hi), 64'd0);
        check_eq("rst_lo", 64'(result_lo), 64'd0);
        reset = 1'b0;
        step();

        run_check("m7xm3", 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b0);
        run_check("mminsq", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h4000_0000, 32'h0000_0000, 33, 1'b0);
        run_check("mm1sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0001, 33, 1'b0);
        run_check("dm7by2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
        run_check("d100by7", 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 32'd14, 33, 1'b0);
        run_check("d5by0", 32'd5, 32'd0, 1'b0, 1'b1, 32'd2, 32'd14, 1, 1'b1);
        run_check("dminbym1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 32'h8000_0000, 33, 1'b0);

        // div_start while a multiply is running must be ignored.
        launch(32'h0000_1234, 32'h0000_0100, 1'b1, 1'b0);
        while (cyc < 5) step();
        op_b      = 32'd0;
        div_start = 1'b1;
        step();
        div_start = 1'b0;
        wait_done();
        check_eq("ign_lat", 64'(cyc), 64'd33);
        check_eq("ign_hi", 64'(result_hi), 64'd0);
        check_eq("ign_lo", 64'(result_lo), 64'h0012_3400);
        check_eq("ign_dz", 64'(div_zero), 64'd0);
        count_dones(40, ndone);
        check_eq("ign_no_second_done", 64'(ndone), 64'd0);
        check_eq("ign_idle_busy", 64'(busy), 64'd0);

        run_check("both", 32'd100, 32'd7, 1'b1, 1'b1, 32'd0, 32'd700, 33, 1'b0);

        // Reset in the middle of a multiply aborts it.
        launch(32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0);
        while (cyc < 10) step();
        reset = 1'b1;
        step();
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        check_eq("abort_hi", 64'(result_hi), 64'd0);
        check_eq("abort_lo", 64'(result_lo), 64'd0);
        reset = 1'b0;
        count_dones(40, ndone);
        check_eq("abort_no_done", 64'(ndone), 64'd0);

        run_check("post_rst", 32'h1234_5678, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0001, 32'h2345_6780, 33, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed multiply/divide engine driven by the multicycle control unit's Mult, Div and DivZero states.
- Consumes the A/B register outputs and a start strobe from the control unit. Produces 64-bit results for the HI/LO registers, plus done, busy and div_zero flags.
- The control unit holds its state until done is seen, then pulses HI_writeControl/LO_writeControl. On div_zero it branches to the DivZero exception state.

Parameters:
- WIDTH, 32, operand width; also the iteration count per operation.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- op_a  in  WIDTH  multiplicand / dividend (register A).
- op_b  in  WIDTH  multiplier / divisor (register B).
- mult_start  in  1  start a signed multiply; sampled only in IDLE.
- div_start  in  1  start a signed divide; sampled only in IDLE.
- result_hi  out  WIDTH  multiply: product[63:32]; divide: remainder.
- result_lo  out  WIDTH  multiply: product[31:0]; divide: quotient.
- busy  out  1  high while in MULT, DIV or FINISH.
- done  out  1  one-cycle pulse; results valid from this cycle onward.
- div_zero  out  1  one-cycle pulse, coincident with done, when a divide had op_b == 0.

Behaviour:
- Reset: state = IDLE. result_hi, result_lo, busy, done and div_zero all 0. Internal counter and working registers are cleared.
- Reset mid-operation aborts the operation. No done is produced; the reset values appear on the edge where reset is sampled.
- State IDLE:
  - mult_start = 1 at an edge: latch op_a and op_b, counter = 0, go to MULT.
  - else div_start = 1 and op_b != 0: latch operand magnitudes and sign bits, go to DIV.
  - else div_start = 1 and op_b == 0: go directly to FINISH with the zero flag set.
  - Both starts high in the same cycle: multiply wins and div_start is ignored.
- Starts seen in any state other than IDLE are ignored; no queuing.
- State MULT: radix-2 Booth over the 2*WIDTH+1-bit accumulator {P_hi, P_lo, q-1}.
  - One iteration per cycle: add/subtract the multiplicand into P_hi by {P_lo[0], q-1}, then arithmetic shift right by 1.
  - After WIDTH iterations (counter == WIDTH-1 on the last one), go to FINISH.
- State DIV: restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles, then FINISH.
  - Sign fix-up happens on entry to FINISH.
  - Quotient is truncated toward zero; it is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - -2^(WIDTH-1) / -1 wraps: quotient 0x80000000, remainder 0. No overflow flag.
- State FINISH (exactly one cycle):
  - done = 1 and busy = 1.
  - result_hi/result_lo are loaded on the edge entering FINISH; div_zero = 1 if the zero flag is set.
  - For divide-by-zero, result_hi/result_lo retain their previous values.
  - Next state is IDLE.
- Results hold until the next completed operation or reset.
- Latency, with start sampled at edge 0:
  - MULT/DIV occupy cycles 1..WIDTH; FINISH (done high) is cycle WIDTH+1, i.e. cycle 33 when WIDTH = 32.
  - Divide-by-zero: FINISH is cycle 1.
- busy is high in cycles 1..done inclusive. A new start is accepted at the edge ending the FINISH cycle's successor, i.e. the first IDLE cycle.
- Arithmetic is two's complement throughout. The Booth adder is WIDTH+1 bits wide, so that -2^(WIDTH-1) is handled correctly.

Test Plan:
1. op_a = 7, op_b = 0xFFFFFFFD (-3), mult_start for one cycle -> done exactly 33 cycles after the start edge; result_hi = 0xFFFFFFFF, result_lo = 0xFFFFFFEB; busy falls the cycle after done.
2. op_a = 0x80000000, op_b = 0x80000000, multiply -> result_hi = 0x40000000, result_lo = 0x00000000. Then 0xFFFFFFFF * 0xFFFFFFFF -> result_hi = 0, result_lo = 1.
3. Divide op_a = 0xFFFFFFF9 (-7), op_b = 2 -> result_lo = 0xFFFFFFFD, result_hi = 0xFFFFFFFF. Divide 100 / 7 -> result_lo = 14, result_hi = 2. Divide 0x80000000 / 0xFFFFFFFF -> result_lo = 0x80000000, result_hi = 0.
4. After the 100/7 divide, divide 5 / 0 -> done and div_zero high together in cycle 1, low in cycle 2; result_hi/result_lo stay at 2/14.
5. Pulse div_start while busy with a multiply -> ignored; the multiply result is correct and there is no second done. Assert mult_start and div_start in the same cycle -> multiply result only, div_zero = 0.
6. Assert reset at cycle 10 of a multiply -> the next cycle shows busy = 0, done = 0, results = 0, and no done follows. A new multiply started after that completes correctly.
